frame_check: RTL and testbench
==============================

// Module: frame_check
// PURPOSE
//  Parametrised UART RX frame checker; successor to the single-bit stop check.
//  Consumes the sampled bit stream of one frame, starting after a validated start bit.
//  Computes parity over the data bits, then checks the parity bit and one or two stop bits.
//  Sits between data sampling and the RX FSM: raises sticky error flags, pulses a
//  per-frame verdict and keeps saturating per-type error counters for status readback.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame, legal range 5..9
//  CNT_WIDTH   8  width of each error counter
// PORTS
//  CLK          in   1           system clock, rising edge
//  RST          in   1           asynchronous, active-low reset
//  Frame_start  in   1           pulse: start bit validated, next Smp_valid is data bit 0
//  Smp_valid    in   1           pulse: Smp_bit holds one sampled bit
//  Smp_bit      in   1           majority-voted bit value
//  Par_en       in   1           1 = frame carries a parity bit
//  Par_typ      in   1           0 = even, 1 = odd
//  Stop2        in   1           1 = two stop bits
//  Flags_Done   in   1           FSM has consumed the flags; clears Par_err/Stp_err
//  Clr_cnt      in   1           synchronous clear of both counters
//  Frame_done   out  1           1-cycle pulse: verdict valid
//  Frame_ok     out  1           valid with Frame_done: no parity error and no stop error
//  Par_err      out  1           sticky parity error flag
//  Stp_err      out  1           sticky stop error flag
//  Busy         out  1           a frame is in progress
//  Par_err_cnt  out  CNT_WIDTH   saturating parity error count
//  Stp_err_cnt  out  CNT_WIDTH   saturating stop error count
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; parity accumulator 0; latched config 0.
//  Config latch: Par_en, Par_typ and Stop2 are latched on Frame_start and held for the frame.
//  FSM states and transitions:
//   - IDLE -> DATA on Frame_start.
//   - DATA: XOR each Smp_bit into the accumulator; bit counter counts 0..DATA_WIDTH-1.
//     After the last data bit: -> PARITY if Par_en, else -> STOP.
//   - PARITY: one Smp_valid. Parity error = acc ^ Smp_bit ^ Par_typ, i.e. nonzero means error.
//     -> STOP.
//   - STOP: one Smp_valid, or two if Stop2. Any stop sample == 0 records a stop error.
//     After the final stop sample -> REPORT.
//   - REPORT: single cycle. Frame_done = 1. Frame_ok = ~(perr|serr).
//     Par_err <= perr, Stp_err <= serr. -> IDLE.
//  Latency: Frame_done is asserted exactly 1 cycle after the cycle carrying the last stop Smp_valid.
//  Busy: 1 in DATA, PARITY, STOP and REPORT.
//  Smp_valid is ignored in IDLE and in REPORT.
//  Sticky flags: Par_err/Stp_err hold their value until Flags_Done or the next Frame_start,
//   which clears them.
//   - Frame_done and Flags_Done in the same cycle: the new verdict wins.
//   - Frame_start mid-frame: abort, restart at DATA bit 0, clear accumulator and flags.
//     No verdict is issued for the aborted frame.
//   - Frame_start and Smp_valid in the same cycle: Frame_start wins, the sample is dropped.
//  Counters: in REPORT, each counter increments by 1 if its error bit is set; it saturates
//   at 2^CNT_WIDTH-1 and never wraps.
//   - Clr_cnt has priority over an increment in the same cycle.
//   - Counters are unaffected by Flags_Done and by frame aborts.
//  Reset asserted mid-frame: immediate return to IDLE with all outputs 0, no Frame_done.
// STRUCTURE
//  Package uart_rx_pkg:
//   - FSM state encoding: IDLE, DATA, PARITY, STOP, REPORT
//   - PAR_EVEN = 1'b0, PAR_ODD = 1'b1
//   - $clog2(DATA_WIDTH) bit-counter width
//  Sub-module sat_counter #(CNT_WIDTH), with inputs inc and clr; instantiated twice,
//   once per error type.
// TESTING
//  - Reset defaults: DATA_WIDTH=8, even parity, 1 stop. Send 0xA5 (parity 0) with parity bit 0
//    and stop 1 -> Frame_done 1 cycle later, Frame_ok=1, both flags 0, counters 0.
//  - Parity error: odd parity, 0x01 with parity bit 1 -> Par_err=1, Frame_ok=0, Par_err_cnt=1.
//    Par_err holds until Flags_Done, then drops the next cycle.
//  - Stop error: Stop2=1, stop samples 1 then 0 -> Stp_err=1. Verdict comes only after the
//    second stop sample. Stp_err_cnt=1.
//  - Abort: Frame_start after 3 data bits, then a clean 0x3C frame -> exactly one Frame_done,
//    Frame_ok=1, and no stale parity from the aborted frame.
//  - Saturation: CNT_WIDTH=2, 5 parity-error frames -> Par_err_cnt sticks at 3.
//    Clr_cnt asserted together with a 6th error frame -> count 0.
//  - Collisions: Flags_Done in the same cycle as an error Frame_done -> flag set.
//    RST low mid-STOP -> all outputs 0, no Frame_done pulse.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX frame checker.
//   - frame FSM state encoding
//   - parity type encodings
//   - bit-counter width helper
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_REPORT = 3'd4
    } frame_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Width of a counter that indexes data bits 0..dw-1.
    function automatic int bit_cnt_w(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage

// File: rtl/frame_check_if.sv
// Bus between the RX sampler/FSM (master) and the frame checker (slave).
//   master drives: Frame_start, Smp_valid, Smp_bit, Par_en, Par_typ, Stop2,
//                  Flags_Done, Clr_cnt
//   slave drives:  Frame_done, Frame_ok, Par_err, Stp_err, Busy,
//                  Par_err_cnt, Stp_err_cnt
interface frame_check_if #(parameter int CNT_WIDTH = 8);
    logic                 Frame_start;
    logic                 Smp_valid;
    logic                 Smp_bit;
    logic                 Par_en;
    logic                 Par_typ;
    logic                 Stop2;
    logic                 Flags_Done;
    logic                 Clr_cnt;
    logic                 Frame_done;
    logic                 Frame_ok;
    logic                 Par_err;
    logic                 Stp_err;
    logic                 Busy;
    logic [CNT_WIDTH-1:0] Par_err_cnt;
    logic [CNT_WIDTH-1:0] Stp_err_cnt;

    modport master (
        output Frame_start, Smp_valid, Smp_bit, Par_en, Par_typ, Stop2,
               Flags_Done, Clr_cnt,
        input  Frame_done, Frame_ok, Par_err, Stp_err, Busy,
               Par_err_cnt, Stp_err_cnt
    );

    modport slave (
        input  Frame_start, Smp_valid, Smp_bit, Par_en, Par_typ, Stop2,
               Flags_Done, Clr_cnt,
        output Frame_done, Frame_ok, Par_err, Stp_err, Busy,
               Par_err_cnt, Stp_err_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for the per-type error counts.
//   CLK   in  clock
//   RST   in  asynchronous active-low reset
//   inc_i in  add one (ignored once at all-ones)
//   clr_i in  synchronous clear, wins over inc_i
//   cnt_o out current count
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/frame_check.sv
// UART RX frame checker. Walks one frame (data, optional parity, one or two
// stop bits) after a validated start bit, issues a one-cycle verdict, keeps
// sticky parity/stop error flags and saturating error counters.
//   CLK  in  system clock
//   RST  in  asynchronous active-low reset
//   bus  slave side of frame_check_if (sample stream, config, flag/counter
//        control in; verdict, flags, busy and counters out)
module frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic          CLK,
    input  logic          RST,
    frame_check_if.slave  bus
);

    localparam int              BCW      = bit_cnt_w(DATA_WIDTH);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_WIDTH - 1);

    frame_state_e   state_q, state_d;
    logic [BCW-1:0] bitcnt_q, bitcnt_d;
    logic           acc_q, acc_d;
    logic           perr_q, perr_d;        // verdict of the frame in progress
    logic           serr_q, serr_d;
    logic           stop_idx_q, stop_idx_d;
    logic           par_en_q, par_en_d;
    logic           par_typ_q, par_typ_d;
    logic           stop2_q, stop2_d;
    logic           par_err_q, par_err_d;  // sticky flags seen by the FSM
    logic           stp_err_q, stp_err_d;
    logic           report;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        acc_d      = acc_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        stop_idx_d = stop_idx_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        stop2_d    = stop2_q;
        par_err_d  = par_err_q;
        stp_err_d  = stp_err_q;

        if (bus.Flags_Done) begin
            par_err_d = 1'b0;
            stp_err_d = 1'b0;
        end

        // Frame_start restarts from any state and swallows a coincident sample.
        if (bus.Frame_start) begin
            state_d    = ST_DATA;
            bitcnt_d   = '0;
            acc_d      = 1'b0;
            perr_d     = 1'b0;
            serr_d     = 1'b0;
            stop_idx_d = 1'b0;
            par_en_d   = bus.Par_en;
            par_typ_d  = bus.Par_typ;
            stop2_d    = bus.Stop2;
            par_err_d  = 1'b0;
            stp_err_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DATA: begin
                    if (bus.Smp_valid) begin
                        acc_d = acc_q ^ bus.Smp_bit;
                        if (bitcnt_q == LAST_BIT) begin
                            bitcnt_d = '0;
                            state_d  = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bus.Smp_valid) begin
                        perr_d  = acc_q ^ bus.Smp_bit ^ (par_typ_q == PAR_ODD);
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bus.Smp_valid) begin
                        if (!bus.Smp_bit) serr_d = 1'b1;
                        if (stop2_q && !stop_idx_q) stop_idx_d = 1'b1;
                        else                        state_d    = ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    // Loaded after the Flags_Done clear so a new verdict wins.
                    par_err_d = perr_q;
                    stp_err_d = serr_q;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            acc_q      <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            acc_q      <= acc_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            stop_idx_q <= stop_idx_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            stop2_q    <= stop2_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    assign report         = (state_q == ST_REPORT);
    assign bus.Frame_done = report;
    assign bus.Frame_ok   = report & ~(perr_q | serr_q);
    assign bus.Par_err    = par_err_q;
    assign bus.Stp_err    = stp_err_q;
    assign bus.Busy       = (state_q != ST_IDLE);

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc_i (report & perr_q),
        .clr_i (bus.Clr_cnt),
        .cnt_o (bus.Par_err_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stp_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc_i (report & serr_q),
        .clr_i (bus.Clr_cnt),
        .cnt_o (bus.Stp_err_cnt)
    );

endmodule

// File: tb/tb_frame_check.sv
module tb_frame_check;
    import uart_rx_pkg::*;

    localparam int DW   = 8;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    frame_check_if #(.CNT_WIDTH(CW)) bus ();

    frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: sticky flags and saturating counts.
    bit m_pflag = 1'b0;
    bit m_sflag = 1'b0;
    int m_pcnt  = 0;
    int m_scnt  = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_par_err"}, int'(bus.Par_err), int'(m_pflag));
        chk({tag, "_stp_err"}, int'(bus.Stp_err), int'(m_sflag));
        chk({tag, "_par_cnt"}, int'(bus.Par_err_cnt), m_pcnt);
        chk({tag, "_stp_cnt"}, int'(bus.Stp_err_cnt), m_scnt);
    endtask

    // Sends one complete frame with random idle gaps, then checks the verdict
    // and the flag/counter state after the report cycle.
    task automatic frame(input string tag, input logic [7:0] d,
                         input bit pen, input bit ptyp, input bit st2,
                         input bit pbit, input bit s0, input bit s1,
                         input bit fd, input bit clr);
        bit bits[$];
        int spur = 0;
        bit e_perr, e_serr;
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(s0);
        if (st2) bits.push_back(s1);

        // Even-parity frames carry an even number of ones including the parity bit.
        e_perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(ptyp));
        e_serr = !s0 || (st2 && !s1);

        // Start, with a junk sample in the same cycle that must be dropped.
        bus.Frame_start = 1'b1;
        bus.Par_en      = pen;
        bus.Par_typ     = ptyp;
        bus.Stop2       = st2;
        bus.Smp_valid   = 1'($urandom_range(0, 1));
        bus.Smp_bit     = 1'($urandom_range(0, 1));
        step();
        bus.Frame_start = 1'b0;
        bus.Smp_valid   = 1'b0;
        m_pflag = 1'b0;
        m_sflag = 1'b0;
        // Config must be held from the start pulse, not followed live.
        bus.Par_en  = 1'($urandom_range(0, 1));
        bus.Par_typ = 1'($urandom_range(0, 1));
        bus.Stop2   = 1'($urandom_range(0, 1));

        for (int i = 0; i < bits.size(); i++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                spur += int'(bus.Frame_done);
            end
            bus.Smp_valid = 1'b1;
            bus.Smp_bit   = bits[i];
            step();
            bus.Smp_valid = 1'b0;
            if (i != bits.size() - 1) spur += int'(bus.Frame_done);
        end

        chk({tag, "_early_done"}, spur, 0);
        chk({tag, "_done"}, int'(bus.Frame_done), 1);
        chk({tag, "_ok"}, int'(bus.Frame_ok), int'(!(e_perr || e_serr)));

        // Report cycle: optional flag ack / counter clear, junk sample ignored.
        bus.Flags_Done = fd;
        bus.Clr_cnt    = clr;
        bus.Smp_valid  = 1'($urandom_range(0, 1));
        bus.Smp_bit    = 1'($urandom_range(0, 1));
        step();
        bus.Flags_Done = 1'b0;
        bus.Clr_cnt    = 1'b0;
        bus.Smp_valid  = 1'b0;

        if (fd) begin
            m_pflag = 1'b0;
            m_sflag = 1'b0;
        end
        m_pflag = e_perr;
        m_sflag = e_serr;
        if (clr) begin
            m_pcnt = 0;
            m_scnt = 0;
        end else begin
            if (e_perr && m_pcnt < CMAX) m_pcnt++;
            if (e_serr && m_scnt < CMAX) m_scnt++;
        end

        chk({tag, "_done_pulse"}, int'(bus.Frame_done), 0);
        chk({tag, "_busy_after"}, int'(bus.Busy), 0);
        chk_state(tag);
    endtask

    initial begin
        bit aborted_done;
        bus.Frame_start = 1'b0;
        bus.Smp_valid   = 1'b0;
        bus.Smp_bit     = 1'b0;
        bus.Par_en      = 1'b0;
        bus.Par_typ     = PAR_EVEN;
        bus.Stop2       = 1'b0;
        bus.Flags_Done  = 1'b0;
        bus.Clr_cnt     = 1'b0;

        // Reset defaults.
        repeat (2) step();
        chk("rst_done", int'(bus.Frame_done), 0);
        chk("rst_ok", int'(bus.Frame_ok), 0);
        chk("rst_busy", int'(bus.Busy), 0);
        chk_state("rst");
        RST = 1'b1;
        step();

        // Clean frame, even parity, one stop.
        frame("clean_a5", 8'hA5, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // Parity error, odd parity; flag holds until acknowledged.
        frame("par_err", 8'h01, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        chk("par_hold", int'(bus.Par_err), 1);
        bus.Flags_Done = 1'b1;
        step();
        bus.Flags_Done = 1'b0;
        m_pflag = 1'b0;
        chk("par_ack", int'(bus.Par_err), 0);

        // Two stop bits, second one bad.
        frame("stp_err", 8'h5A, 1'b0, PAR_EVEN, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort after three ones, then a clean 0x3C frame.
        bus.Frame_start = 1'b1;
        bus.Par_en      = 1'b1;
        step();
        bus.Frame_start = 1'b0;
        aborted_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Smp_valid = 1'b1;
            bus.Smp_bit   = 1'b1;
            step();
            aborted_done |= bus.Frame_done;
        end
        bus.Smp_valid = 1'b0;
        m_pflag = 1'b0;
        m_sflag = 1'b0;
        chk("abort_busy", int'(bus.Busy), 1);
        frame("abort_3c", 8'h3C, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("abort_no_done", int'(aborted_done), 0);

        // Saturation, then clear racing a sixth error.
        for (int i = 0; i < 5; i++)
            frame("sat", 8'h01, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sat_cnt", int'(bus.Par_err_cnt), CMAX);
        frame("sat_clr", 8'h01, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_cnt", int'(bus.Par_err_cnt), 0);

        // Ack in the same cycle as an error verdict: verdict wins.
        frame("coll", 8'h07, 1'b1, PAR_EVEN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("coll_flag", int'(bus.Par_err), 1);

        // Randomised frames.
        for (int n = 0; n < 30; n++)
            frame("rnd", 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));

        // Make sure there is something for reset to wipe.
        frame("pre_rst", 8'h03, 1'b1, PAR_ODD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while in STOP of a two-stop frame.
        bus.Frame_start = 1'b1;
        bus.Par_en      = 1'b1;
        bus.Stop2       = 1'b1;
        step();
        bus.Frame_start = 1'b0;
        for (int i = 0; i < DW + 2; i++) begin
            bus.Smp_valid = 1'b1;
            bus.Smp_bit   = 1'b1;
            step();
        end
        bus.Smp_valid = 1'b0;
        chk("mid_busy", int'(bus.Busy), 1);
        bus.Smp_valid = 1'b1;
        RST = 1'b0;
        #1;
        m_pflag = 1'b0;
        m_sflag = 1'b0;
        m_pcnt  = 0;
        m_scnt  = 0;
        chk("mrst_done", int'(bus.Frame_done), 0);
        chk("mrst_ok", int'(bus.Frame_ok), 0);
        chk("mrst_busy", int'(bus.Busy), 0);
        chk_state("mrst");
        aborted_done = 1'b0;
        repeat (2) begin
            step();
            aborted_done |= bus.Frame_done;
        end
        RST = 1'b1;
        repeat (4) begin
            step();
            aborted_done |= bus.Frame_done;
        end
        bus.Smp_valid = 1'b0;
        chk("mrst_no_done", int'(aborted_done), 0);
        chk("mrst_idle", int'(bus.Busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
